// File: rtl/flag_register.sv
`default_nettype none
// ============================================================================
//  Module   : flag_register
//  Purpose  : Derives the Z/N/V status flags from flag-setting ALU operations,
//             holds them in a flag register and keeps a DEPTH-entry LIFO so the
//             flags survive trap/interrupt entry and return.
//  Revision : 1.0 - initial release
// ============================================================================
module flag_register #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             a_msb,
   input  logic             b_msb,
   input  logic [1:0]       alu_op,
   input  logic             flag_we,
   input  logic             push,
   input  logic             pop,
   output logic             Z,
   output logic             N,
   output logic             V,
   output logic             stk_empty,
   output logic             stk_full,
   output logic             err
);

   // Counter must represent 0..DEPTH inclusive
   localparam int               PTR_W    = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] CNT_ZERO = '0;
   localparam logic [PTR_W-1:0] CNT_ONE  = PTR_W'(1);

   // ALU operation encodings; everything else behaves as logic/move
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;

   // Flag register
   logic z_q, z_d;
   logic n_q, n_d;
   logic v_q, v_d;

   // Stack bookkeeping and status
   logic [PTR_W-1:0] cnt_q, cnt_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             err_q, err_d;

   // Stack storage, each entry is {Z,N,V}
   logic [2:0] stk_q [DEPTH];
   logic [2:0] stk_d [DEPTH];

   // Freshly derived flags for this cycle's ALU result
   logic res_msb;
   logic z_new;
   logic n_new;
   logic v_new;

   // Decoded stack requests
   logic req_conflict;
   logic pop_ok;
   logic pop_err;
   logic push_ok;
   logic push_err;
   logic flag_upd;
   logic [2:0] top_entry;

   // Derive Z/N/V from the ALU result; logic ops keep the current V
   always_comb begin
      res_msb = alu_result[WIDTH-1];
      z_new   = (alu_result == '0);
      n_new   = res_msb;
      case (alu_op)
         OP_ADD:  v_new = (a_msb == b_msb) & (res_msb != a_msb);
         OP_SUB:  v_new = (a_msb != b_msb) & (res_msb != a_msb);
         default: v_new = v_q;
      endcase
   end

   // Resolve the per-cycle request priority between push, pop and flag_we
   always_comb begin
      req_conflict = push & pop;
      pop_ok       = pop  & ~push & (cnt_q != CNT_ZERO);
      pop_err      = pop  & ~push & (cnt_q == CNT_ZERO);
      push_ok      = push & ~pop  & (cnt_q != CNT_FULL);
      push_err     = push & ~pop  & (cnt_q == CNT_FULL);
      // Any pop request (legal, illegal or colliding with push) masks flag_we
      flag_upd     = flag_we & ~pop;
   end

   // Select the entry at the top of the stack (index cnt_q-1)
   always_comb begin
      top_entry = stk_q[0];
      for (int i = 0; i < DEPTH; i++) begin
         if (cnt_q == PTR_W'(i + 1)) begin
            top_entry = stk_q[i];
         end
      end
   end

   // Next-state for flags, counter, status outputs and stack contents
   always_comb begin
      z_d   = z_q;
      n_d   = n_q;
      v_d   = v_q;
      cnt_d = cnt_q;
      err_d = req_conflict | pop_err | push_err;
      for (int i = 0; i < DEPTH; i++) begin
         stk_d[i] = stk_q[i];
      end

      if (pop_ok) begin
         // Restored value wins over any concurrent ALU update
         {z_d, n_d, v_d} = top_entry;
         cnt_d           = cnt_q - CNT_ONE;
      end else begin
         if (push_ok) begin
            // The saved copy is always the pre-edge flag value
            for (int i = 0; i < DEPTH; i++) begin
               if (cnt_q == PTR_W'(i)) begin
                  stk_d[i] = {z_q, n_q, v_q};
               end
            end
            cnt_d = cnt_q + CNT_ONE;
         end
         if (flag_upd) begin
            z_d = z_new;
            n_d = n_new;
            v_d = v_new;
         end
      end

      empty_d = (cnt_d == CNT_ZERO);
      full_d  = (cnt_d == CNT_FULL);
   end

   // Flag, counter and status registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z_q     <= 1'b1;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
         cnt_q   <= CNT_ZERO;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         z_q     <= z_d;
         n_q     <= n_d;
         v_q     <= v_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         err_q   <= err_d;
      end
   end

   // Stack storage needs no reset; entries above the count are never read
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         stk_q[i] <= stk_d[i];
      end
   end

   assign Z         = z_q;
   assign N         = n_q;
   assign V         = v_q;
   assign stk_empty = empty_q;
   assign stk_full  = full_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flag_register
//  Purpose  : Directed and randomised self-checking bench for flag_register.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flag_register;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_LOG = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] alu_result;
   logic             a_msb;
   logic             b_msb;
   logic [1:0]       alu_op;
   logic             flag_we;
   logic             push;
   logic             pop;
   logic             Z, N, V;
   logic             stk_empty;
   logic             stk_full;
   logic             err;

   int n_checks = 0;
   int n_fail   = 0;

   flag_register #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_result (alu_result),
      .a_msb      (a_msb),
      .b_msb      (b_msb),
      .alu_op     (alu_op),
      .flag_we    (flag_we),
      .push       (push),
      .pop        (pop),
      .Z          (Z),
      .N          (N),
      .V          (V),
      .stk_empty  (stk_empty),
      .stk_full   (stk_full),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of stimulus, then sample 1 time unit after the edge
   task automatic drive(input logic we, input logic ps, input logic pp,
                        input logic [1:0] op, input logic [31:0] res,
                        input logic am, input logic bm);
      flag_we    = we;
      push       = ps;
      pop        = pp;
      alu_op     = op;
      alu_result = res;
      a_msb      = am;
      b_msb      = bm;
      @(posedge clk);
      #1;
      flag_we = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Flags compared as {Z,N,V}
   task automatic chkf(input string tag, input logic [2:0] exp);
      n_checks++;
      assert ({Z, N, V} === exp) else begin
         n_fail++;
         $error("FAIL %s: observed ZNV=%b expected ZNV=%b", tag, {Z, N, V}, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a, b, res;
      logic [32:0] wide;
      logic [1:0]  op;
      logic [2:0]  exp_f;

      rst        = 1'b1;
      flag_we    = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      alu_op     = OP_ADD;
      alu_result = '0;
      a_msb      = 1'b0;
      b_msb      = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chkf("reset_flags", 3'b100);
      chk1("reset_empty", stk_empty, 1'b1);
      chk1("reset_full",  stk_full,  1'b0);
      chk1("reset_err",   err,       1'b0);

      // Basic derivation
      drive(1, 0, 0, OP_ADD, 32'h8000_0000, 0, 0);
      chkf("add_ovf", 3'b011);
      drive(1, 0, 0, OP_SUB, 32'h0000_0000, 0, 0);
      chkf("sub_zero", 3'b100);
      drive(1, 0, 0, OP_ADD, 32'h8000_0000, 0, 0);
      chkf("add_ovf2", 3'b011);
      drive(1, 0, 0, OP_LOG, 32'h0000_0001, 0, 0);
      chkf("logic_keep_v", 3'b001);
      drive(1, 0, 0, OP_RSV, 32'h0000_0000, 1, 1);
      chkf("reserved_keep_v", 3'b101);
      drive(0, 0, 0, OP_ADD, 32'h8000_0000, 0, 0);
      chkf("no_we_stable", 3'b101);

      // Asynchronous reset in the middle of a cycle with a non-empty stack
      drive(1, 0, 0, OP_ADD, 32'h8000_0000, 0, 0);
      drive(0, 1, 0, OP_LOG, 32'h0, 0, 0);
      chk1("push_not_empty", stk_empty, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chkf("async_rst_flags", 3'b100);
      chk1("async_rst_empty", stk_empty, 1'b1);
      chk1("async_rst_err",   err,       1'b0);
      #1 rst = 1'b0;

      // Push with flag_we in the same cycle saves the old flags
      drive(1, 1, 0, OP_ADD, 32'h8000_0000, 0, 1);
      chkf("push_we_flags", 3'b010);
      chk1("push_we_empty", stk_empty, 1'b0);
      drive(0, 0, 1, OP_LOG, 32'h0, 0, 0);
      chkf("pop_restore_old", 3'b100);
      chk1("pop_empty", stk_empty, 1'b1);

      // Fill the stack, each push also changing the live flags
      drive(1, 1, 0, OP_ADD, 32'h8000_0000, 0, 0);  // save 100 -> 011
      drive(1, 1, 0, OP_LOG, 32'h0000_0000, 0, 0);  // save 011 -> 101
      drive(1, 1, 0, OP_LOG, 32'h0000_0005, 0, 0);  // save 101 -> 001
      chk1("three_not_full", stk_full, 1'b0);
      drive(1, 1, 0, OP_SUB, 32'h0000_0000, 0, 0);  // save 001 -> 100
      chkf("fill_flags", 3'b100);
      chk1("fill_full", stk_full, 1'b1);
      chk1("fill_err",  err,      1'b0);
      drive(1, 1, 0, OP_ADD, 32'h8000_0000, 0, 1);  // overflow push, flags -> 010
      chk1("ovf_push_err",  err,      1'b1);
      chk1("ovf_push_full", stk_full, 1'b1);
      chkf("ovf_push_we",   3'b010);
      drive(0, 0, 0, OP_LOG, 32'h0, 0, 0);
      chk1("err_one_cycle", err, 1'b0);

      // Drain in reverse order
      drive(0, 0, 1, OP_LOG, 32'h0, 0, 0);
      chkf("pop1", 3'b001);
      chk1("pop1_not_full", stk_full, 1'b0);
      drive(0, 0, 1, OP_LOG, 32'h0, 0, 0);
      chkf("pop2", 3'b101);
      drive(0, 0, 1, OP_LOG, 32'h0, 0, 0);
      chkf("pop3", 3'b011);
      drive(0, 0, 1, OP_LOG, 32'h0, 0, 0);
      chkf("pop4", 3'b100);
      chk1("pop4_empty", stk_empty, 1'b1);
      drive(1, 0, 1, OP_ADD, 32'h8000_0000, 0, 0);  // underflow pop, flag_we ignored
      chk1("underflow_err", err, 1'b1);
      chkf("underflow_flags", 3'b100);
      chk1("underflow_empty", stk_empty, 1'b1);
      drive(0, 0, 0, OP_LOG, 32'h0, 0, 0);
      chk1("underflow_err_clr", err, 1'b0);

      // Simultaneous push and pop, then pop colliding with flag_we
      drive(1, 0, 0, OP_ADD, 32'h8000_0000, 0, 0);  // 011
      drive(0, 1, 0, OP_LOG, 32'h0, 0, 0);          // save 011
      drive(1, 0, 0, OP_LOG, 32'h0000_0000, 0, 0);  // 101
      drive(1, 1, 1, OP_ADD, 32'h8000_0000, 0, 1);
      chk1("pushpop_err",   err,       1'b1);
      chkf("pushpop_flags", 3'b101);
      chk1("pushpop_empty", stk_empty, 1'b0);
      drive(1, 0, 1, OP_LOG, 32'h0000_0005, 0, 0);
      chkf("pop_we_restore", 3'b011);
      chk1("pop_we_empty",   stk_empty, 1'b1);
      chk1("pop_we_err",     err,       1'b0);

      // Directed boundary: 0x80000000 - 1 overflows
      drive(1, 0, 0, OP_SUB, 32'h7FFF_FFFF, 1, 0);
      chkf("sub_min_minus_one", 3'b001);
      exp_f = 3'b001;

      // Randomised ALU operations against a sign-extension reference model
      for (int i = 0; i < 40; i++) begin
         a  = $urandom;
         b  = (i % 7 == 0) ? a : $urandom;
         op = 2'($urandom_range(0, 3));
         case (op)
            OP_ADD: begin
               wide = {a[31], a} + {b[31], b};
               res  = wide[31:0];
               exp_f[0] = wide[32] ^ wide[31];
            end
            OP_SUB: begin
               wide = {a[31], a} - {b[31], b};
               res  = wide[31:0];
               exp_f[0] = wide[32] ^ wide[31];
            end
            default: begin
               res = (i % 5 == 0) ? 32'h0 : (a ^ b);
            end
         endcase
         exp_f[2] = (res == 32'h0);
         exp_f[1] = res[31];
         drive(1, 0, 0, op, res, a[31], b[31]);
         chkf($sformatf("random_%0d", i), exp_f);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
